// File: rtl/demux_dispatch_pkg.sv
// Shared types and defaults for the demux dispatch controller.
// Optional statistics outputs are enabled by defining DEMUX_DISPATCH_STATS_EN.
package demux_dispatch_pkg;

   localparam int DW_DEF      = 8;
   localparam int TIMEOUT_DEF = 15;
   localparam int NCHAN       = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/demux_rr_pick.sv
// Combinational circular priority pick: first set mask bit at or after ptr, wrapping 7->0.
module demux_rr_pick
   import demux_dispatch_pkg::*;
(
   input  logic [2:0]       ptr,
   input  logic [NCHAN-1:0] mask,
   output logic [2:0]       idx,
   output logic             found
);

   logic [2:0] cand;

   // Walk offsets nearest-first; the first hit wins and later hits are ignored.
   always_comb begin
      idx   = ptr;
      found = 1'b0;
      cand  = ptr;
      for (int i = 0; i < NCHAN; i++) begin
         cand = ptr + 3'(i);
         if (!found && mask[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// One-to-eight beat dispatcher with addressed / round-robin targeting and SEND timeout.
// Define DEMUX_DISPATCH_STATS_EN to add the beat_cnt / drop_cnt statistics outputs.
module demux_dispatch_ctrl
   import demux_dispatch_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [2:0]    in_dest,
   input  logic          mode,
   input  logic [7:0]    chan_en,
   output logic [7:0]    out_valid,
   output logic [DW-1:0] out_data,
   input  logic [7:0]    out_ready,
   output logic [2:0]    cur_sel,
   output logic          busy,
   output logic          drop_pulse
`ifdef DEMUX_DISPATCH_STATS_EN
   ,
   output logic [15:0]   beat_cnt,
   output logic [7:0]    drop_cnt
`endif
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [DW-1:0] data_q, data_d;
   logic [2:0]    sel_q, sel_d;
   logic [2:0]    rr_q, rr_d;
   logic [7:0]    wait_q, wait_d;
   logic          mode_q, mode_d;
   logic          drop_q, drop_d;
   logic          xfer;
   logic [2:0]    acc_idx, rt_idx;
   logic          acc_found, rt_found;

   demux_rr_pick u_acc_pick (
      .ptr   (rr_q),
      .mask  (chan_en),
      .idx   (acc_idx),
      .found (acc_found)
   );

   // Retarget search skips the channel that just timed out.
   demux_rr_pick u_rt_pick (
      .ptr   (sel_q + 3'd1),
      .mask  (chan_en & ~(8'b1 << sel_q)),
      .idx   (rt_idx),
      .found (rt_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         sel_q   <= '0;
         rr_q    <= '0;
         wait_q  <= '0;
         mode_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
         wait_q  <= wait_d;
         mode_q  <= mode_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      wait_d  = wait_q;
      mode_d  = mode_q;
      drop_d  = 1'b0;
      xfer    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d = in_data;
               mode_d = mode;
               wait_d = '0;
               if (mode) begin
                  sel_d = acc_idx;
                  if (acc_found) state_d = SEND;
                  else           drop_d  = 1'b1;
               end else begin
                  sel_d = in_dest;
                  if (chan_en[in_dest]) state_d = SEND;
                  else                  drop_d  = 1'b1;
               end
            end
         end
         SEND: begin
            if (out_ready[sel_q]) begin
               xfer    = 1'b1;
               state_d = IDLE;
               if (mode_q) rr_d = sel_q + 3'd1;
            end else if (wait_q == WAIT_LAST) begin
               if (mode_q && rt_found) begin
                  sel_d  = rt_idx;
                  wait_d = '0;
               end else begin
                  state_d = IDLE;
                  drop_d  = 1'b1;
               end
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // in_ready is gated by rst_n so it reads low throughout reset.
   always_comb begin
      in_ready   = rst_n && (state_q == IDLE);
      busy       = (state_q != IDLE);
      out_valid  = (state_q == SEND) ? (8'b1 << sel_q) : 8'b0;
      out_data   = data_q;
      cur_sel    = sel_q;
      drop_pulse = drop_q;
   end

`ifdef DEMUX_DISPATCH_STATS_EN
   logic [15:0] beat_q;
   logic [7:0]  dcnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= '0;
         dcnt_q <= '0;
      end else begin
         if (xfer && beat_q != 16'hFFFF) beat_q <= beat_q + 16'd1;
         if (drop_d && dcnt_q != 8'hFF)  dcnt_q <= dcnt_q + 8'd1;
      end
   end

   assign beat_cnt = beat_q;
   assign drop_cnt = dcnt_q;
`endif

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameters: DW, default 8, data width. TIMEOUT, default 15, SEND wait limit in cycles (1..255).
REQ-002 One clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  source beat valid.
- in_ready  out  1  controller can accept a beat.
- in_data  in  DW  source beat payload.
- in_dest  in  3  target channel; used in addressed mode only.
- mode  in  1  0 = addressed, 1 = round-robin.
- chan_en  in  8  per-channel enable mask.
- out_valid  out  8  one-hot valid for the selected channel.
- out_data  out  DW  payload shared by all channels.
- out_ready  in  8  per-channel sink ready.
- cur_sel  out  3  currently selected channel.
- busy  out  1  high when state != IDLE.
- drop_pulse  out  1  one-cycle pulse when a beat is discarded.

Function
REQ-010 The FSM SHALL have states IDLE and SEND; drop is a one-cycle action taken on an IDLE->IDLE or SEND->IDLE transition.
REQ-011 in_ready SHALL equal (state == IDLE); a beat is accepted on the edge where in_valid && in_ready.
REQ-012 On accept, in_data SHALL be latched into out_data, and sel chosen as follows:
- Addressed mode: sel = in_dest.
- Round-robin mode: sel = first enabled channel at or after rr_ptr, wrapping 7->0.
REQ-013 If the chosen channel is disabled (addressed mode), or chan_en == 0 (round-robin mode), the beat SHALL be dropped: drop_pulse = 1 next cycle, state stays IDLE.
REQ-014 Otherwise state SHALL go to SEND; out_valid = (1 << sel) from the cycle after accept (latency 1), and 0 in IDLE.
REQ-015 A transfer completes when out_valid[sel] && out_ready[sel]. The next state SHALL be IDLE, and rr_ptr = (sel + 1) mod 8 in round-robin mode. rr_ptr is unchanged in addressed mode.
REQ-016 Throughput SHALL be at most one beat per two cycles; there is no IDLE bypass.
REQ-017 wait_cnt (8 bits) SHALL clear on entry to SEND, and increment each SEND cycle without transfer.
REQ-018 When wait_cnt reaches TIMEOUT:
- Addressed mode: drop the beat and return to IDLE.
- Round-robin mode: retarget to the next enabled channel after sel using the live chan_en, clear wait_cnt, and stay in SEND.
- Round-robin mode with no other enabled channel: drop.
REQ-019 mode, in_dest and chan_en changes during SEND SHALL NOT affect the current beat, except the retarget in REQ-018.
REQ-020 out_data and cur_sel SHALL hold their values until the next accept.

Reset
REQ-030 On rst_n low, asynchronously: state = IDLE, out_valid = 0, out_data = 0, cur_sel = 0, rr_ptr = 0, wait_cnt = 0, drop_pulse = 0, busy = 0.
REQ-031 Reset mid-SEND SHALL discard the held beat without asserting drop_pulse.
REQ-032 in_ready SHALL be 0 while rst_n is low, and 1 in the first cycle after release.

Configuration
REQ-040 Macro DEMUX_DISPATCH_STATS_EN defined: the block SHALL add two outputs:
- beat_cnt[15:0]: completed transfers, saturating at 0xFFFF.
- drop_cnt[7:0]: drops, saturating at 0xFF.
Both reset to 0.
REQ-041 Macro undefined: these ports and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-050 Package demux_dispatch_pkg SHALL hold the state enum, the DW and TIMEOUT defaults, and the channel-count constant (8).
REQ-051 Sub-module demux_rr_pick SHALL be combinational: inputs ptr[2:0] and mask[7:0]; outputs idx[2:0] and found (first set bit at or after ptr, wrapping). It is instantiated for both the accept pick and the timeout retarget.

Verification
REQ-060 Addressed mode, chan_en = 0xFF, in_dest = 5, in_data = 0xA5, out_ready = 0xFF -> out_valid = 0x20 and out_data = 0xA5 one cycle after accept; IDLE the cycle after.
REQ-061 Round-robin mode, chan_en = 0x81, 4 beats, sinks always ready -> channels 0, 7, 0, 7.
REQ-062 Addressed mode, in_dest = 3, chan_en[3] = 0 -> in_ready stays 1, drop_pulse = 1 once, out_valid stays 0.
REQ-063 Round-robin mode, chan_en = 0x06, out_ready = 0x04 -> beat targets channel 1, retargets to channel 2 after 15 cycles, then transfers.
REQ-064 Assert rst_n low mid-SEND -> out_valid = 0 immediately, no drop_pulse; with DEMUX_DISPATCH_STATS_EN, beat_cnt = 0.
REQ-065 With DEMUX_DISPATCH_STATS_EN, 70000 beats sent -> beat_cnt = 0xFFFF.
